// File: rtl/match_sched_pkg.sv
// Shared types and constants for the sequence-match scheduler.
package match_pkg;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_LEAD,
    MS_STREAM,
    MS_DRAIN,
    MS_DONE
  } MS_STATE;

  localparam int unsigned QUIET_CYCLES = 2;
  localparam int unsigned HCW          = 5;

  // One beat of drive toward the shared matcher.
  typedef struct packed {
    logic       valid;
    logic [3:0] num;
    logic [3:0] seq;
  } match_drive_t;

endpackage

// File: rtl/match_sched_if.sv
// Requester-side job bus of the match scheduler.
interface match_sched_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXLEN = 8
);
  localparam int unsigned LW = $clog2(MAXLEN + 1);

  logic [NREQ-1:0]          req;
  logic [NREQ*4-1:0]        job_num;
  logic [NREQ*MAXLEN*4-1:0] job_seq;
  logic [NREQ*LW-1:0]       job_len;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          done;
  logic [3:0]               result;

  modport master (output req, job_num, job_seq, job_len, input gnt, done, result);
  modport slave  (input req, job_num, job_seq, job_len, output gnt, done, result);
endinterface

// File: rtl/match_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/match_sched.sv
// Round-robin scheduler sharing one sequence matcher among NREQ requesters.
module match_sched
  import match_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXLEN = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  match_sched_if.slave rq,
  output logic       m_valid,
  output logic [3:0] m_num,
  output logic [3:0] m_seq,
  input  logic       m_hit
);

  localparam int unsigned LW = $clog2(MAXLEN + 1);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned SW = MAXLEN * 4;

  localparam logic [2:0] ST_IDLE   = 3'(MS_IDLE);
  localparam logic [2:0] ST_LEAD   = 3'(MS_LEAD);
  localparam logic [2:0] ST_STREAM = 3'(MS_STREAM);
  localparam logic [2:0] ST_DRAIN  = 3'(MS_DRAIN);
  localparam logic [2:0] ST_DONE   = 3'(MS_DONE);

  logic [2:0]      state, state_d;
  logic [IW-1:0]   rr_ptr, rr_ptr_d, owner, owner_d;
  logic [SW-1:0]   seq_q, seq_d;
  logic [LW-1:0]   len_q, len_d, idx, idx_d, idx_inc;
  logic [HCW-1:0]  hit_cnt, hit_cnt_d;
  logic [1:0]      quiet, quiet_d, quiet_inc;
  logic [1:0]      dcnt, dcnt_d, dcnt_inc;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [3:0]      result_q, result_d;
  match_drive_t    drv_q, drv_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [3:0]      sel_num;
  logic [SW-1:0]   sel_seq;
  logic [LW-1:0]   sel_len;
  logic            sel_bad;

  rr_arb #(.N(NREQ), .IW(IW)) u_arb (
    .req (rq.req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Job fields of the requester the arbiter currently points at.
  assign sel_num = rq.job_num[int'(arb_idx)*4 +: 4];
  assign sel_seq = rq.job_seq[int'(arb_idx)*SW +: SW];
  assign sel_len = rq.job_len[int'(arb_idx)*LW +: LW];
  assign sel_bad = (sel_len == '0) || (sel_len > LW'(MAXLEN));

  assign idx_inc   = idx + LW'(1);
  assign quiet_inc = m_hit ? 2'd0 : ((quiet == 2'd3) ? 2'd3 : quiet + 2'd1);
  assign dcnt_inc  = (dcnt == 2'd3) ? 2'd3 : dcnt + 2'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    owner_d   = owner;
    seq_d     = seq_q;
    len_d     = len_q;
    idx_d     = idx;
    hit_cnt_d = hit_cnt;
    quiet_d   = quiet;
    dcnt_d    = dcnt;
    gnt_d     = '0;
    done_d    = '0;
    result_d  = '0;
    drv_d     = drv_q;

    case (state)
      ST_IDLE: begin
        if (|rq.req) begin
          gnt_d     = arb_gnt;
          owner_d   = arb_idx;
          rr_ptr_d  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          drv_d.num = sel_num;
          seq_d     = sel_seq;
          len_d     = sel_len;
          hit_cnt_d = '0;
          state_d   = sel_bad ? ST_DONE : ST_LEAD;
        end
      end
      ST_LEAD: begin
        state_d = ST_STREAM;
        idx_d   = '0;
      end
      ST_STREAM: begin
        if (idx_inc == len_q) begin
          state_d   = ST_DRAIN;
          hit_cnt_d = '0;
          quiet_d   = '0;
          dcnt_d    = '0;
        end else begin
          idx_d = idx_inc;
        end
      end
      ST_DRAIN: begin
        quiet_d = quiet_inc;
        dcnt_d  = dcnt_inc;
        if (m_hit && (hit_cnt != '1)) hit_cnt_d = hit_cnt + HCW'(1);
        if ((quiet_inc >= 2'(QUIET_CYCLES)) && (dcnt_inc >= 2'd2)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        done_d   = NREQ'(1) << owner;
        result_d = (hit_cnt == '0) ? 4'd0 : 4'(hit_cnt - HCW'(1));
      end
      default: state_d = ST_IDLE;
    endcase

    // Matcher sees ~num whenever it is not being streamed, so it can never match idle beats.
    drv_d.valid = (state_d == ST_LEAD) || (state_d == ST_STREAM);
    drv_d.seq   = ~drv_d.num;
    if (state_d == ST_STREAM) drv_d.seq = seq_d[int'(idx_d)*4 +: 4];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      seq_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      hit_cnt  <= '0;
      quiet    <= '0;
      dcnt     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      drv_q    <= '{valid: 1'b0, num: 4'h0, seq: 4'hF};
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      owner    <= owner_d;
      seq_q    <= seq_d;
      len_q    <= len_d;
      idx      <= idx_d;
      hit_cnt  <= hit_cnt_d;
      quiet    <= quiet_d;
      dcnt     <= dcnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      drv_q    <= drv_d;
    end
  end

  assign rq.gnt    = gnt_q;
  assign rq.done   = done_q;
  assign rq.result = result_q;
  assign m_valid   = drv_q.valid;
  assign m_num     = drv_q.num;
  assign m_seq     = drv_q.seq;

endmodule

// File: tb/tb_match_sched.sv
// Randomized scoreboard bench for match_sched with a behavioural matcher alongside.
module tb_match_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned MAXLEN = 8;
  localparam int unsigned LW     = $clog2(MAXLEN + 1);

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       m_valid, m_hit;
  logic [3:0] m_num, m_seq;

  match_sched_if #(.NREQ(NREQ), .MAXLEN(MAXLEN)) bus ();

  match_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rq      (bus),
    .m_valid (m_valid),
    .m_num   (m_num),
    .m_seq   (m_seq),
    .m_hit   (m_hit)
  );

  always #5 clock = ~clock;

  logic [3:0]      t_num [NREQ];
  logic [3:0]      t_seq [NREQ][MAXLEN];
  logic [LW-1:0]   t_len [NREQ];
  logic [NREQ-1:0] t_req;

  always_comb begin
    bus.req = t_req;
    for (int i = 0; i < NREQ; i++) begin
      bus.job_num[i*4 +: 4]   = t_num[i];
      bus.job_len[i*LW +: LW] = t_len[i];
      for (int k = 0; k < MAXLEN; k++) bus.job_seq[(i*MAXLEN+k)*4 +: 4] = t_seq[i][k];
    end
  end

  // Matcher: first valid beat arms it, later valid beats count matches,
  // and after the stream it holds hit for count+1 cycles (none if count is 0).
  int mm_st, mm_cnt, mm_hold;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mm_st <= 0; mm_cnt <= 0; mm_hold <= 0; m_hit <= 1'b0;
    end else begin
      case (mm_st)
        0: if (m_valid) begin mm_st <= 1; mm_cnt <= 0; end
        1: begin
          if (m_valid) begin
            if (m_seq == m_num) mm_cnt <= mm_cnt + 1;
          end else if (mm_cnt != 0) begin
            m_hit <= 1'b1; mm_hold <= mm_cnt; mm_st <= 2;
          end else mm_st <= 0;
        end
        default: begin
          if (mm_hold == 0) begin m_hit <= 1'b0; mm_st <= 0; end
          else mm_hold <= mm_hold - 1;
        end
      endcase
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct { int owner; int num; int res; int lat; int mv; } exp_t;
  exp_t sb_q[$];
  int   exp_ptr = 0;
  int   n_done  = 0;
  int   cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: count matches over the job, derive hit burst and latency from it.
  function automatic exp_t model_job(input int i);
    exp_t e;
    int   c, len;
    len     = int'(t_len[i]);
    e.owner = i;
    e.num   = int'(t_num[i]);
    c       = 0;
    if (len >= 1 && len <= MAXLEN) begin
      for (int k = 0; k < len; k++) if (t_seq[i][k] == t_num[i]) c++;
      e.res = c;
      e.mv  = len + 1;
      e.lat = 1 + len + ((c == 0) ? 2 : c + 4) + 1;
    end else begin
      e.res = 0; e.mv = 0; e.lat = 1;
    end
    return e;
  endfunction

  // Monitor: pops the expected job at gnt, checks it at done.
  exp_t cur;
  bit   busy = 1'b0;
  int   gcyc, mv_cnt;
  always @(negedge clock) begin
    if (!reset_n) begin
      sb_q.delete();
      busy = 1'b0;
    end else begin
      if (busy) mv_cnt += int'(m_valid);
      if (bus.gnt != '0) begin
        if (sb_q.size() == 0) chk("gnt_unexpected", int'(bus.gnt), 0);
        else begin
          cur = sb_q.pop_front();
          chk("gnt_order", int'(bus.gnt), 1 << cur.owner);
          chk("m_num_latch", int'(m_num), cur.num);
          chk("lead_valid", int'(m_valid), (cur.mv > 0) ? 1 : 0);
          chk("lead_seq", int'(m_seq), (~cur.num) & 15);
          busy = 1'b1; gcyc = cyc; mv_cnt = int'(m_valid);
        end
      end
      if (bus.done != '0) begin
        if (!busy) chk("done_unexpected", int'(bus.done), 0);
        else begin
          chk("done_owner", int'(bus.done), 1 << cur.owner);
          chk("result", int'(bus.result), cur.res);
          chk("latency", cyc - gcyc, cur.lat);
          chk("valid_cycles", mv_cnt, cur.mv);
          busy = 1'b0;
          n_done++;
        end
      end else chk("result_idle", int'(bus.result), 0);
    end
  end

  task automatic set_job(input int i, input int num, input logic [31:0] sw, input int len);
    t_num[i] = 4'(num);
    t_len[i] = LW'(len);
    for (int k = 0; k < MAXLEN; k++) t_seq[i][k] = sw[k*4 +: 4];
  endtask

  // Issue a set of simultaneous requests; requesters in drop withdraw after the first grant.
  task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] drop);
    int order[$];
    int target, j;
    bit dropped;
    for (int i = 0; i < NREQ; i++) begin
      j = (exp_ptr + i) % NREQ;
      if (mask[j] && (order.size() == 0 || !drop[j])) order.push_back(j);
    end
    foreach (order[n]) sb_q.push_back(model_job(order[n]));
    exp_ptr = (order[order.size()-1] + 1) % NREQ;
    target  = n_done + order.size();
    dropped = 1'b0;
    t_req   = mask;
    for (int c = 0; c < 600 && n_done < target; c++) begin
      @(negedge clock); #1;
      if (bus.gnt != '0) begin
        t_req = t_req & ~bus.gnt;
        if (!dropped) begin t_req = t_req & ~drop; dropped = 1'b1; end
      end
    end
    chk("batch_complete", (n_done >= target) ? 1 : 0, 1);
    t_req = '0;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sw;
    int          vc;
    t_req = '0;
    for (int i = 0; i < NREQ; i++) set_job(i, 0, 32'h0, 0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_num", int'(m_num), 0);
    chk("rst_m_seq", int'(m_seq), 15);
    reset_n = 1'b1;
    @(negedge clock);

    // Single job with three matches, then a no-match job.
    set_job(0, 3, 32'h0000_3313, 4);
    run_batch(4'b0001, 4'b0000);
    set_job(1, 5, 32'h0000_0021, 2);
    run_batch(4'b0010, 4'b0000);

    // Fairness: bring the pointer back to 0, then full contention, then a withdrawal.
    for (int i = 0; i < NREQ; i++) set_job(i, i, (i % 2 == 0) ? 32'(i) : 32'hF, 1);
    run_batch(4'b1000, 4'b0000);
    run_batch(4'b1111, 4'b0000);
    run_batch(4'b1111, 4'b0010);

    // Bad lengths: zero and beyond MAXLEN.
    set_job(2, 7, 32'h7777_7777, 0);
    run_batch(4'b0100, 4'b0000);
    set_job(1, 4, 32'h4444_4444, 9);
    run_batch(4'b0010, 4'b0000);

    // Full-length job where every element matches.
    set_job(3, 9, 32'h9999_9999, 8);
    run_batch(4'b1000, 4'b0000);

    // Random jobs and request patterns.
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        int num, r, len;
        num = $urandom_range(0, 15);
        r   = $urandom_range(0, 9);
        len = (r == 0) ? 0 : (r == 1) ? $urandom_range(9, 15) : $urandom_range(1, 8);
        for (int k = 0; k < MAXLEN; k++)
          sw[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'(num) : 4'($urandom_range(0, 15));
        set_job(i, num, sw, len);
      end
      run_batch(NREQ'($urandom_range(1, 15)),
                ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, 15)) : '0);
    end

    // Reset in the middle of streaming element 2 of a full job.
    set_job(3, 6, 32'h8765_4321, 8);
    sb_q.push_back(model_job(3));
    t_req = 4'b1000;
    vc    = 0;
    for (int c = 0; c < 50 && vc < 4; c++) begin
      @(negedge clock);
      if (bus.gnt != '0) t_req = '0;
      if (m_valid) vc++;
    end
    chk("reach_idx2", vc, 4);
    chk("stream_seq_idx2", int'(m_seq), 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_m_num", int'(m_num), 0);
    chk("mid_rst_m_seq", int'(m_seq), 15);
    chk("mid_rst_gnt", int'(bus.gnt), 0);
    t_req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("mid_rst_done", int'(bus.done), 0);
    end
    reset_n = 1'b1;
    exp_ptr = 0;
    @(negedge clock);
    set_job(1, 2, 32'h0000_0222, 3);
    set_job(3, 6, 32'h0000_0006, 1);
    run_batch(4'b1010, 4'b0000);

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
